// File: rtl/register.sv
// Parameterizable-width load-enable register with synchronous active-low reset.
// data_out is a flop output; there is no combinational path from the inputs to it.
module register #(
   parameter int unsigned       WIDTH       = 16,
   parameter logic [63:0]       RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ctrl,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   // Ternary rather than if/else so an X on ctrl reaches data_out instead of holding.
   always_comb begin
      data_d = data_q;
      data_d = ctrl ? data_in : data_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) data_q <= RST_VAL;
      else        data_q <= data_d;
   end

   assign data_out = data_q;

endmodule

// File: tb/tb_register.sv
// Directed self-checking bench for register: default 16-bit instance plus an
// 8-bit instance with a truncated non-zero reset value.
module tb_register;

   logic        clk;
   logic        reset;
   logic        ctrl;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic [7:0]  data_out8;

   int unsigned total;
   int unsigned bad;

   register dut (
      .clk      (clk),
      .reset    (reset),
      .ctrl     (ctrl),
      .data_in  (data_in),
      .data_out (data_out)
   );

   register #(
      .WIDTH       (8),
      .RESET_VALUE (64'h1A5)
   ) dut8 (
      .clk      (clk),
      .reset    (reset),
      .ctrl     (ctrl),
      .data_in  (data_in[7:0]),
      .data_out (data_out8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; ctrl = 1'b1; data_in = 16'hFFFF;
      edge_step();
      total++;
      if (data_out !== 16'h0000) begin
         bad++; $display("FAIL reset_clear: got %h expected %h", data_out, 16'h0000);
      end
      total++;
      if (data_out8 !== 8'hA5) begin
         bad++; $display("FAIL reset_value_w8: got %h expected %h", data_out8, 8'hA5);
      end
      reset = 1'b1; ctrl = 1'b0; data_in = 16'h1234;
      edge_step();
      total++;
      if (data_out !== 16'h0000) begin
         bad++; $display("FAIL reset_then_hold: got %h expected %h", data_out, 16'h0000);
      end
      total++;
      if (data_out8 !== 8'hA5) begin
         bad++; $display("FAIL reset_then_hold_w8: got %h expected %h", data_out8, 8'hA5);
      end
   endtask

   task automatic test_load();
      ctrl = 1'b1; data_in = 16'h1234;
      #2;
      total++;
      if (data_out !== 16'h0000) begin
         bad++; $display("FAIL load_before_edge: got %h expected %h", data_out, 16'h0000);
      end
      edge_step();
      total++;
      if (data_out !== 16'h1234) begin
         bad++; $display("FAIL load: got %h expected %h", data_out, 16'h1234);
      end
      total++;
      if (data_out8 !== 8'h34) begin
         bad++; $display("FAIL load_w8: got %h expected %h", data_out8, 8'h34);
      end
   endtask

   task automatic test_hold();
      ctrl = 1'b0; data_in = 16'hBEEF;
      for (int i = 0; i < 3; i++) begin
         edge_step();
         total++;
         if (data_out !== 16'h1234) begin
            bad++; $display("FAIL hold[%0d]: got %h expected %h", i, data_out, 16'h1234);
         end
         data_in = ~data_in;
      end
   endtask

   task automatic test_continuous();
      logic [15:0] vec [3];
      vec[0] = 16'h0001; vec[1] = 16'hFFFF; vec[2] = 16'h8000;
      ctrl = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_in = vec[i];
         edge_step();
         total++;
         if (data_out !== vec[i]) begin
            bad++; $display("FAIL continuous[%0d]: got %h expected %h", i, data_out, vec[i]);
         end
      end
      total++;
      if (data_out8 !== 8'h00) begin
         bad++; $display("FAIL continuous_w8: got %h expected %h", data_out8, 8'h00);
      end
   endtask

   task automatic load_5a5a(input string tag);
      reset = 1'b1; ctrl = 1'b1; data_in = 16'h5A5A;
      edge_step();
      total++;
      if (data_out !== 16'h5A5A) begin
         bad++; $display("FAIL %s_preload: got %h expected %h", tag, data_out, 16'h5A5A);
      end
   endtask

   task automatic test_reset_beats_hold();
      load_5a5a("rst_hold");
      reset = 1'b0; ctrl = 1'b0;
      edge_step();
      total++;
      if (data_out !== 16'h0000) begin
         bad++; $display("FAIL reset_beats_hold: got %h expected %h", data_out, 16'h0000);
      end
   endtask

   task automatic test_reset_beats_load();
      load_5a5a("rst_load");
      reset = 1'b0; ctrl = 1'b1; data_in = 16'h7777;
      edge_step();
      total++;
      if (data_out !== 16'h0000) begin
         bad++; $display("FAIL reset_beats_load: got %h expected %h", data_out, 16'h0000);
      end
      edge_step();
      total++;
      if (data_out !== 16'h0000) begin
         bad++; $display("FAIL reset_held: got %h expected %h", data_out, 16'h0000);
      end
      total++;
      if (data_out8 !== 8'hA5) begin
         bad++; $display("FAIL reset_held_w8: got %h expected %h", data_out8, 8'hA5);
      end
      reset = 1'b1; data_in = 16'h4321;
      edge_step();
      total++;
      if (data_out !== 16'h4321) begin
         bad++; $display("FAIL release_load: got %h expected %h", data_out, 16'h4321);
      end
   endtask

   task automatic test_no_async();
      load_5a5a("no_async");
      ctrl = 1'b0;
      #1 reset = 1'b0;
      #2;
      total++;
      if (data_out !== 16'h5A5A) begin
         bad++; $display("FAIL no_async_clear: got %h expected %h", data_out, 16'h5A5A);
      end
      edge_step();
      total++;
      if (data_out !== 16'h0000) begin
         bad++; $display("FAIL sync_clear: got %h expected %h", data_out, 16'h0000);
      end
      reset = 1'b1;
   endtask

   initial begin
      total = 0; bad = 0;
      reset = 1'b1; ctrl = 1'b0; data_in = '0;
      @(negedge clk);
      test_reset();
      test_load();
      test_hold();
      test_continuous();
      test_reset_beats_hold();
      test_reset_beats_load();
      test_no_async();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
